// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone B3 arbiter sharing one memory slave
// among ibus (0), dbus (1) and debug (2). A grant lasts for the owner's whole
// cyc tenure so bursts stay atomic; a per-access watchdog turns a stalled
// slave into a one-cycle bus error for the owner.
module wb_mem_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [3*NUM_MASTERS-1:0]  m_cti_i,
  input  logic [2*NUM_MASTERS-1:0]  m_bte_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int                IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0]        TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0]     LAST_RST    = IW'(NUM_MASTERS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t                 state_r;
  logic [IW-1:0]          owner_r;
  logic [IW-1:0]          last_r;
  logic [7:0]             wdog_r;
  logic [NUM_MASTERS-1:0] grant_r;

  logic [IW-1:0]          winner_s;
  logic                   req_any_s;
  logic [IW-1:0]          cand_s;
  int                     rr_sum_s;
  logic                   owner_cyc_s;
  logic                   owner_stb_s;
  logic                   resp_any_s;
  logic                   fire_s;

  // One-hot decode of a master index.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_MASTERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign owner_cyc_s = m_cyc_i[owner_r];
  assign owner_stb_s = m_stb_i[owner_r];
  assign resp_any_s  = s_ack_i | s_err_i | s_rty_i;
  // Fire cycle is decoded purely from registered state so the error pulse is clean.
  assign fire_s      = (state_r == ST_OWNED) && (TIMEOUT_LIM != 8'd0) && (wdog_r == TIMEOUT_LIM);
  assign grant_o     = grant_r;

  // Round-robin search upward from last+1 (with wrap) for the first cyc requester.
  always_comb begin
    winner_s  = '0;
    req_any_s = 1'b0;
    cand_s    = '0;
    rr_sum_s  = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rr_sum_s = int'(last_r) + 1 + i;
      cand_s   = (rr_sum_s >= NUM_MASTERS) ? IW'(rr_sum_s - NUM_MASTERS) : IW'(rr_sum_s);
      if (!req_any_s && m_cyc_i[cand_s]) begin
        req_any_s = 1'b1;
        winner_s  = cand_s;
      end else begin
        req_any_s = req_any_s;
      end
    end
  end

  // Arbiter FSM: ownership, round-robin pointer, grant vector and watchdog counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
      owner_r <= '0;
      last_r  <= LAST_RST;
      wdog_r  <= 8'd0;
      grant_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wdog_r <= 8'd0;
          if (req_any_s) begin
            state_r <= ST_OWNED;
            owner_r <= winner_s;
            last_r  <= winner_s;
            grant_r <= onehot(winner_s);
          end else begin
            grant_r <= '0;
          end
        end
        ST_OWNED: begin
          if (fire_s || !owner_cyc_s) begin
            // Release: watchdog expiry or owner ended its cyc tenure.
            state_r <= ST_IDLE;
            grant_r <= '0;
            wdog_r  <= 8'd0;
          end else if (resp_any_s) begin
            wdog_r <= 8'd0;
          end else if (owner_stb_s && (TIMEOUT_LIM != 8'd0) && (wdog_r != TIMEOUT_LIM)) begin
            wdog_r <= wdog_r + 8'd1;
          end else begin
            wdog_r <= wdog_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          wdog_r  <= 8'd0;
        end
      endcase
    end
  end

  // Owner request mux to the slave and slave response routing back to the owner.
  always_comb begin
    m_dat_o = s_dat_i;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = 3'd0;
    s_bte_o = 2'd0;
    if (state_r == ST_OWNED) begin
      s_adr_o = m_adr_i[int'(owner_r)*32 +: 32];
      s_dat_o = m_dat_i[int'(owner_r)*32 +: 32];
      s_sel_o = m_sel_i[int'(owner_r)*4 +: 4];
      s_we_o  = m_we_i[owner_r];
      s_cti_o = m_cti_i[int'(owner_r)*3 +: 3];
      s_bte_o = m_bte_i[int'(owner_r)*2 +: 2];
      if (fire_s) begin
        // Watchdog fire cycle: abort the access, slave responses are ignored.
        m_err_o[owner_r] = 1'b1;
      end else begin
        s_cyc_o          = owner_cyc_s;
        s_stb_o          = owner_stb_s;
        m_ack_o[owner_r] = s_ack_i;
        m_err_o[owner_r] = s_err_i;
        m_rty_o[owner_r] = s_rty_i;
      end
    end else begin
      s_cyc_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: dut_a has an 8-cycle watchdog, dut_b has
// the watchdog disabled; both see the same master and slave stimulus.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] m_adr = '0;
  logic [95:0] m_dat = '0;
  logic [11:0] m_sel = '0;
  logic [2:0]  m_we  = '0;
  logic [2:0]  m_cyc = '0;
  logic [2:0]  m_stb = '0;
  logic [8:0]  m_cti = '0;
  logic [5:0]  m_bte = '0;
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0;
  logic        s_err = 1'b0;
  logic        s_rty = 1'b0;

  logic [31:0] a_m_dat, b_m_dat, a_s_adr, b_s_adr, a_s_dat, b_s_dat;
  logic [2:0]  a_m_ack, b_m_ack, a_m_err, b_m_err, a_m_rty, b_m_rty;
  logic [3:0]  a_s_sel, b_s_sel;
  logic        a_s_we, b_s_we, a_s_cyc, b_s_cyc, a_s_stb, b_s_stb;
  logic [2:0]  a_s_cti, b_s_cti, a_grant, b_grant;
  logic [1:0]  a_s_bte, b_s_bte;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.NUM_MASTERS(3), .TIMEOUT_CYCLES(8)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(a_m_dat), .m_ack_o(a_m_ack), .m_err_o(a_m_err), .m_rty_o(a_m_rty),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_cti_o(a_s_cti), .s_bte_o(a_s_bte),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(a_grant)
  );

  wb_mem_arbiter #(.NUM_MASTERS(3), .TIMEOUT_CYCLES(0)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(b_m_dat), .m_ack_o(b_m_ack), .m_err_o(b_m_err), .m_rty_o(b_m_rty),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_cti_o(b_s_cti), .s_bte_o(b_s_bte),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(b_grant)
  );

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one master's request fields; write data is derived from the address.
  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[n]          = cyc;
    m_stb[n]          = stb;
    m_we[n]           = we;
    m_adr[32*n +: 32] = adr;
    m_dat[32*n +: 32] = adr ^ 32'hA5A5_0000;
    m_sel[4*n +: 4]   = 4'hF;
    m_cti[3*n +: 3]   = cti;
    m_bte[2*n +: 2]   = 2'b00;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++) set_m(n, 1'b1, 1'b1, 1'b1, 32'h0000_1000 + 32'(n), 3'b010);
    step();
    total++; if (a_grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=%b", a_grant, 3'b000); end
    total++; if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0) begin bad++; $display("FAIL reset_cyc_stb got=%b%b exp=00", a_s_cyc, a_s_stb); end
    total++; if (a_s_adr !== 32'd0 || a_s_we !== 1'b0) begin bad++; $display("FAIL reset_s_outputs adr=%h we=%b exp=0", a_s_adr, a_s_we); end
    total++; if (a_m_ack !== 3'b000 || a_m_err !== 3'b000 || a_m_rty !== 3'b000) begin bad++; $display("FAIL reset_responses ack=%b err=%b rty=%b exp=000", a_m_ack, a_m_err, a_m_rty); end
  endtask

  task automatic test_single();
    do_reset();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b000);
    #1;
    total++; if (a_s_cyc !== 1'b0) begin bad++; $display("FAIL single_pregrant_cyc got=%b exp=0", a_s_cyc); end
    step();
    total++; if (a_s_cyc !== 1'b1 || a_grant !== 3'b010) begin bad++; $display("FAIL single_grant cyc=%b grant=%b exp=1/010", a_s_cyc, a_grant); end
    total++; if (a_s_adr !== 32'h0000_0100 || a_s_we !== 1'b0) begin bad++; $display("FAIL single_adr adr=%h we=%b exp=00000100/0", a_s_adr, a_s_we); end
    total++; if (a_m_ack !== 3'b000) begin bad++; $display("FAIL single_early_ack got=%b exp=000", a_m_ack); end
    step();
    step();
    // Ack arrives two cycles after stb; owner drops cyc in the same cycle.
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 3'b000);
    #1;
    total++; if (a_m_ack !== 3'b010) begin bad++; $display("FAIL single_ack got=%b exp=%b", a_m_ack, 3'b010); end
    total++; if (a_m_dat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_dat got=%h exp=%h", a_m_dat, 32'hDEAD_BEEF); end
    step();
    s_ack = 1'b0;
    #1;
    total++; if (a_grant !== 3'b000 || a_s_cyc !== 1'b0) begin bad++; $display("FAIL single_release grant=%b cyc=%b exp=000/0", a_grant, a_s_cyc); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) set_m(n, 1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(4*n), 3'b000);
    step();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      exp_g = 3'b001 << (t % 3);
      total++; if (a_grant !== exp_g) begin bad++; $display("FAIL rr_grant_%0d got=%b exp=%b", t, a_grant, exp_g); end
      s_ack = 1'b1;
      set_m(t % 3, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 3'b000);
      #1;
      total++; if (a_m_ack !== exp_g) begin bad++; $display("FAIL rr_ack_%0d got=%b exp=%b", t, a_m_ack, exp_g); end
      step();
      s_ack = 1'b0;
      total++; if (a_grant !== 3'b000 || a_s_cyc !== 1'b0) begin bad++; $display("FAIL rr_idle_%0d grant=%b cyc=%b exp=000/0", t, a_grant, a_s_cyc); end
      set_m(t % 3, 1'b1, 1'b1, 1'b0, 32'h0000_2000 + 32'(4*(t % 3)), 3'b000);
    end
  endtask

  task automatic test_burst();
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 3'b010);
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h0000_0900, 3'b000);
    step();
    for (int b = 0; b < 4; b++) begin
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0200 + 32'(4*b), (b == 3) ? 3'b111 : 3'b010);
      s_ack = 1'b1;
      #1;
      total++; if (a_grant !== 3'b001 || a_m_ack !== 3'b001) begin bad++; $display("FAIL burst_beat_%0d grant=%b ack=%b exp=001/001", b, a_grant, a_m_ack); end
      total++; if (a_s_adr !== 32'h0000_0200 + 32'(4*b)) begin bad++; $display("FAIL burst_adr_%0d got=%h exp=%h", b, a_s_adr, 32'h0000_0200 + 32'(4*b)); end
      step();
    end
    // End-of-burst cti seen, but cyc stays high: grant must hold.
    s_ack = 1'b0;
    m_stb[0] = 1'b0;
    step();
    total++; if (a_grant !== 3'b001 || a_s_cti !== 3'b111) begin bad++; $display("FAIL burst_hold grant=%b cti=%b exp=001/111", a_grant, a_s_cti); end
    m_cyc[0] = 1'b0;
    step();
    total++; if (a_grant !== 3'b000) begin bad++; $display("FAIL burst_release got=%b exp=000", a_grant); end
    step();
    total++; if (a_grant !== 3'b100 || a_s_we !== 1'b1) begin bad++; $display("FAIL burst_next_owner grant=%b we=%b exp=100/1", a_grant, a_s_we); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 3'b000);
    step();
    total++; if (a_s_dat !== 32'hA5A5_0300 || a_s_sel !== 4'hF || a_s_bte !== 2'b00) begin bad++; $display("FAIL wd_write_fields dat=%h sel=%h bte=%b exp=a5a50300/f/00", a_s_dat, a_s_sel, a_s_bte); end
    for (int c = 0; c < 8; c++) begin
      total++; if (a_m_err !== 3'b000 || a_s_cyc !== 1'b1) begin bad++; $display("FAIL wd_wait_%0d err=%b cyc=%b exp=000/1", c, a_m_err, a_s_cyc); end
      step();
    end
    // Fire cycle: a late ack must be ignored.
    s_ack = 1'b1;
    #1;
    total++; if (a_m_err !== 3'b100) begin bad++; $display("FAIL wd_fire_err got=%b exp=%b", a_m_err, 3'b100); end
    total++; if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_m_ack !== 3'b000) begin bad++; $display("FAIL wd_fire_bus cyc=%b stb=%b ack=%b exp=0/0/000", a_s_cyc, a_s_stb, a_m_ack); end
    step();
    s_ack = 1'b0;
    total++; if (a_m_err !== 3'b000 || a_grant !== 3'b000) begin bad++; $display("FAIL wd_after_fire err=%b grant=%b exp=000/000", a_m_err, a_grant); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 3'b010);
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0404, 3'b010);
    #1;
    total++; if (a_grant !== 3'b010 || a_s_cyc !== 1'b1) begin bad++; $display("FAIL rmb_owned grant=%b cyc=%b exp=010/1", a_grant, a_s_cyc); end
    rst = 1'b1;
    #1;
    total++; if (a_s_cyc !== 1'b0 || a_grant !== 3'b000) begin bad++; $display("FAIL rmb_async cyc=%b grant=%b exp=0/000", a_s_cyc, a_grant); end
    total++; if (a_m_ack !== 3'b000 || a_m_err !== 3'b000) begin bad++; $display("FAIL rmb_no_resp ack=%b err=%b exp=000/000", a_m_ack, a_m_err); end
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 3'b000);
    step();
    rst = 1'b0;
    step();
    total++; if (a_grant !== 3'b001 || a_s_adr !== 32'h0000_0500) begin bad++; $display("FAIL rmb_regrant grant=%b adr=%h exp=001/00000500", a_grant, a_s_adr); end
  endtask

  task automatic test_wd_disabled();
    logic err_seen;
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 3'b000);
    err_seen = 1'b0;
    step();
    for (int c = 0; c < 1000; c++) begin
      if (b_m_err !== 3'b000 || b_grant !== 3'b001) err_seen = 1'b1;
      step();
    end
    total++; if (err_seen !== 1'b0) begin bad++; $display("FAIL nowd_stall_err got=%b exp=0", err_seen); end
    s_ack = 1'b1;
    s_dat = 32'h1234_5678;
    #1;
    total++; if (b_m_ack !== 3'b001 || b_m_err !== 3'b000) begin bad++; $display("FAIL nowd_ack ack=%b err=%b exp=001/000", b_m_ack, b_m_err); end
    total++; if (b_m_dat !== 32'h1234_5678) begin bad++; $display("FAIL nowd_dat got=%h exp=%h", b_m_dat, 32'h1234_5678); end
    step();
    s_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_watchdog();
    test_reset_mid_burst();
    test_wd_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Round-robin Wishbone B3 arbiter that shares the single system memory slave among the CPU instruction bus, CPU data bus and JTAG debug master inside `orpsoc_top`. It holds a grant for the owner's whole `cyc` tenure, so classic and incrementing bursts are atomic. A per-access watchdog returns a bus error if the slave stops responding.

## Interface
- `NUM_MASTERS`, 3: number of requesters; master 0 = ibus, 1 = dbus, 2 = debug.
- `TIMEOUT_CYCLES`, 255: cycles with `stb` high and no response before the watchdog fires; 0 disables the watchdog.
- `wb_clk_i`  in  1  system clock; all logic on the rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `m_adr_i`  in  32*NUM_MASTERS  master addresses; master n in bits [32n+31:32n].
- `m_dat_i`  in  32*NUM_MASTERS  master write data.
- `m_sel_i`  in  4*NUM_MASTERS  byte selects.
- `m_we_i`, `m_cyc_i`, `m_stb_i`  in  NUM_MASTERS  per-master write enable, cycle and strobe.
- `m_cti_i`  in  3*NUM_MASTERS  cycle type; `m_bte_i`  in  2*NUM_MASTERS  burst type.
- `m_dat_o`  out  32  read data, broadcast to all masters (copy of `s_dat_i`).
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  NUM_MASTERS  per-master responses; only the owner's bit can be high.
- `s_adr_o` (32), `s_dat_o` (32), `s_sel_o` (4), `s_we_o` (1), `s_cyc_o` (1), `s_stb_o` (1), `s_cti_o` (3), `s_bte_o` (2)  out  slave request signals.
- `s_dat_i` (32), `s_ack_i`, `s_err_i`, `s_rty_i` (1 each)  in  slave responses.
- `grant_o`  out  NUM_MASTERS  one-hot current owner; all zero when idle.

## Operation
- Two states.
  - IDLE: no owner; `s_cyc_o` = `s_stb_o` = 0; all other `s_*` outputs = 0.
  - OWNED: the owner index is registered.
- IDLE -> OWNED: at a clock edge where any `m_cyc_i` is high. The winner is the first requester found searching upward (with wrap) from `last + 1`, where `last` is the previous owner. `last` resets to NUM_MASTERS-1, so master 0 wins first.
- OWNED: the owner's `adr`, `dat`, `sel`, `we`, `cyc`, `stb`, `cti` and `bte` are muxed combinationally to `s_*`. `s_ack_i`, `s_err_i` and `s_rty_i` are routed combinationally to the owner's bit only.
- OWNED -> IDLE occurs at any edge where either of these holds:
  - the owner's `m_cyc_i` is low;
  - the watchdog fires.
- Every release leaves one idle cycle before the next grant. Other masters' `cyc`/`stb` have no effect while OWNED.
- Burst atomicity: the grant is never revoked while the owner holds `cyc`, whatever `cti` is (including 3'b111 end-of-burst while `cyc` stays high).
- Watchdog:
  - 8-bit counter, saturating at TIMEOUT_CYCLES.
  - Cleared in IDLE and on any cycle with `s_ack_i | s_err_i | s_rty_i`.
  - Increments on each OWNED cycle with `s_stb_o` high and no response.
  - When the counter equals TIMEOUT_CYCLES (nonzero), the arbiter holds a fire cycle:
    - `m_err_o[owner]` = 1 (registered, one cycle);
    - `s_cyc_o` = `s_stb_o` = 0;
    - slave responses ignored;
    - the next edge goes to IDLE.
  - `TIMEOUT_CYCLES` must fit in 8 bits (≤ 255).

## Timing
- Reset (asynchronous assert, synchronous-edge deassert use):
  - state = IDLE, `grant_o` = 0, `last` = NUM_MASTERS-1, counter = 0;
  - all `s_*` outputs and all `m_ack_o`, `m_err_o`, `m_rty_o` bits = 0.
- Arbitration latency: `m_cyc_i` high at edge k gives `s_cyc_o` high in the cycle after edge k, i.e. 1 cycle.
- Response path: `m_ack_o`, `m_rty_o`, `m_dat_o` and non-watchdog `m_err_o` have zero latency from the slave.
- Simultaneous requests: resolved only in IDLE by round-robin; no master waits more than NUM_MASTERS-1 tenures.
- Owner drops `cyc` in the same cycle the slave acks: the ack is delivered, and release happens at that edge.
- Reset mid-transfer: `s_cyc_o` drops immediately and asynchronously, no response is generated, and arbitration restarts from master 0.

## Test plan
- Single request: master 1 (dbus) does a read of 0x100 with the slave acking 2 cycles after `stb`.
  - `s_cyc_o` rises 1 cycle after `m_cyc_i[1]`.
  - `m_ack_o` = 3'b010 and `m_dat_o` = `s_dat_i`.
  - `grant_o` returns to 0 one cycle after `cyc` drops.
- Round-robin: all three masters hold `cyc` from reset and each does one single access.
  - Grant order is 0, 1, 2, 0.
  - There is one idle cycle between tenures.
- Burst hold: master 0 runs a 4-beat incrementing burst (`cti` 010, then 111 on the last beat) while master 2 requests.
  - Master 2 gets no grant until master 0's `cyc` falls.
  - All 4 acks go to master 0 only.
- Watchdog: TIMEOUT_CYCLES = 8 and the slave never acks master 2's write.
  - `m_err_o[2]` pulses for exactly one cycle after 8 strobed cycles.
  - `s_cyc_o` is 0 in that cycle; the arbiter is IDLE next.
- Reset mid-burst: assert `wb_rst_i` during beat 2 of a master 1 burst.
  - `s_cyc_o` and `grant_o` go to 0 without waiting for a clock.
  - After release, the first grant goes to master 0 when masters 0 and 1 both request.
- Watchdog disabled: TIMEOUT_CYCLES = 0 and the slave stalls 1000 cycles, then acks.
  - No `m_err_o` is generated.
  - The ack reaches the owner.
